ascon_finalize: RTL
===================

Name: ascon_finalize

Overview:
- Final stage of the ASCON-128 PL datapath. Sits directly downstream of the plaintext-absorb stage.
- Consumes the 320-bit state left after the last padded plaintext block (`pt_sout2_final`).
- Injects the key, runs the p12 permutation iteratively over several cycles, and produces the 128-bit authentication tag.
- Its outputs go to the AXI result registers read by the PS.

Parameters:
- `ROUNDS_PER_CYCLE`, default 1: number of ASCON rounds unrolled per clock. Legal values are 1, 2, 3, 4, 6 and 12; any other value is a synthesis error. `NCYC = 12/ROUNDS_PER_CYCLE`.
- `KEY_BITS`, default 128: key width. Fixed for ASCON-128 and exists only for readability.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to finalize. Sampled only in IDLE or DONE.
- `fin_sin`  in  320: state from the absorb stage, as words x0..x4 with x0 = [319:256]. Sampled on the start edge.
- `key`  in  128: ASCON-128 key. Sampled on the start edge.
- `busy`  out  1: high while in ROUND.
- `tag_valid`  out  1: one-cycle pulse when the tag is ready.
- `tag_out`  out  128: tag T.
- `fin_sout`  out  320: full post-p12 state, kept for debug.

Behaviour:
- Reset values (while `rst` is low):
  - FSM goes to IDLE.
  - `busy`, `tag_valid`, `tag_out`, `fin_sout`, the internal state register and the round counter are all 0.
  - Reset is honoured at any time, including mid-ROUND. The partial result is discarded and no `tag_valid` is produced.
- FSM states:
  - IDLE:
    - If `start`=1 at edge E0, load `S = fin_sin ^ {64'h0, key, 128'h0}` (key XOR into x1 and x2).
    - Clear the round counter `rc` to 0 and go to ROUND.
  - ROUND:
    - On each edge, apply `ROUNDS_PER_CYCLE` rounds with round indices `rc .. rc+R-1` and set `rc += R`.
    - `start` is ignored in this state.
    - On the edge where `rc+R == 12`, register `fin_sout` = permuted S and `tag_out = S'[127:0] ^ key`, set `tag_valid`=1, and go to DONE.
  - DONE:
    - `tag_valid`=1 for exactly this cycle.
    - Next edge: if `start`=1, reload as in IDLE and go to ROUND (back-to-back operation, no bubble). Otherwise go to IDLE.
    - `tag_valid` returns to 0 on that edge in both cases.
- Latency: with `start` at E0, `tag_valid` is high in the cycle after edge E0+NCYC. For R=1 the tag is registered at E12; for R=12 it is registered at E1.
- Output hold: `tag_out` and `fin_sout` hold their value until the next completion or a reset.
- Round function, one round on state x0..x4 (64-bit words):
  - Constant addition: `x2 ^= rcon[i]`, with `rcon` = F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B for i = 0..11, XORed into the low byte.
  - Substitution: the ASCON 5-bit S-box applied bitsliced across the five words.
  - Linear diffusion, each word XORed with two right-rotations of itself:
    - x0 rotations 19, 28
    - x1 rotations 61, 39
    - x2 rotations 1, 6
    - x3 rotations 10, 17
    - x4 rotations 7, 41
- Round counter: `rc` is 4 bits. It never exceeds 12 and has no wrap-around.
- `busy` = (FSM == ROUND). `busy` is 0 during DONE.
- No X-propagation: all datapath registers are written only at load or on a round edge.

Optional Feature:
- Macro: `ASCON_TAG_VERIFY_EN`.
- When defined:
  - Adds input `tag_in[127:0]` (expected tag for decryption, sampled on the start edge) and output `tag_match` (1 bit).
  - `tag_match` is registered on the same edge as `tag_out`: 1 if `tag_in == computed tag`, else 0.
  - Reset value is 0. It holds until the next completion.
  - When `tag_match`=0, `tag_out` is forced to 128'h0 so a failed tag is never released.
- When undefined: neither port exists and `tag_out` is always the computed tag.

Test Plan:
1. KAT, ASCON-128 Count=1 (key and nonce = 000102..0F, empty AD, empty PT):
   - Stimulus: `fin_sin` from the golden model, R=1, pulse `start`.
   - Required: `tag_out` = E355159F292911F794CB1432A0103A8A, with `tag_valid` high exactly 12 cycles after the start edge and `busy` high for the 12 ROUND cycles.
2. Latency sweep: rerun case 1 with R = 2, 3, 4, 6, 12.
   - Required: identical tag, with `tag_valid` at 6, 4, 3, 2 and 1 cycles after the start edge respectively.
3. Start while busy:
   - Stimulus: R=1, second `start` with a different `fin_sin` at cycle 5.
   - Required: it is ignored; only one `tag_valid` appears and the tag equals case 1.
4. Back-to-back: `start` asserted in the DONE cycle with new data.
   - Required: a second `tag_valid` exactly NCYC+1 cycles after the first, with the correct second tag.
5. Reset mid-op:
   - Stimulus: `rst`=0 at cycle 6 of ROUND.
   - Required: all outputs go to 0 immediately and no `tag_valid` appears.
   - After release, a fresh start reproduces the case 1 tag.
6. `ASCON_TAG_VERIFY_EN` defined:
   - `tag_in` = case 1 tag: `tag_match`=1 and `tag_out` = that tag.
   - `tag_in` with bit 0 flipped: `tag_match`=0 and `tag_out`=0.

Source files
------------

// File: rtl/ascon_finalize.sv
// ASCON-128 finalization: key injection, iterative p12 and tag generation.
// Define ASCON_TAG_VERIFY_EN to add the tag_in compare and the tag_match output.
module ascon_finalize #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned KEY_BITS         = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [319:0]        fin_sin,
  input  logic [KEY_BITS-1:0] key,
`ifdef ASCON_TAG_VERIFY_EN
  input  logic [127:0]        tag_in,
  output logic                tag_match,
`endif
  output logic                busy,
  output logic                tag_valid,
  output logic [127:0]        tag_out,
  output logic [319:0]        fin_sout
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 3 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 6 || ROUNDS_PER_CYCLE == 12))
  begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be one of 1, 2, 3, 4, 6, 12");
  end
  if (KEY_BITS != 128) begin : g_bad_key
    $error("KEY_BITS must be 128 for ASCON-128");
  end

  localparam logic [3:0] RStep = 4'(ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    // Round constant: high nibble counts down while low nibble counts up.
    x2 = x2 ^ {56'h0, 4'hf - idx, idx};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  state_e              st_q;
  logic [319:0]        state_q;
  logic [3:0]          rc_q;
  logic [KEY_BITS-1:0] key_q;
  logic [319:0]        s_next;
  logic [127:0]        tag_calc;
`ifdef ASCON_TAG_VERIFY_EN
  logic [127:0]        tag_in_q;
`endif

  always_comb begin
    s_next = state_q;
    for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      s_next = ascon_round(s_next, rc_q + 4'(k));
    end
  end

  assign tag_calc = s_next[127:0] ^ key_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= StIdle;
      state_q   <= '0;
      rc_q      <= '0;
      key_q     <= '0;
      busy      <= 1'b0;
      tag_valid <= 1'b0;
      tag_out   <= '0;
      fin_sout  <= '0;
`ifdef ASCON_TAG_VERIFY_EN
      tag_in_q  <= '0;
      tag_match <= 1'b0;
`endif
    end else begin
      unique case (st_q)
        StIdle, StDone: begin
          tag_valid <= 1'b0;
          busy      <= start;
          if (start) begin
            state_q <= fin_sin ^ {64'h0, key, 128'h0};
            key_q   <= key;
            rc_q    <= '0;
            st_q    <= StRound;
`ifdef ASCON_TAG_VERIFY_EN
            tag_in_q <= tag_in;
`endif
          end else begin
            st_q <= StIdle;
          end
        end
        StRound: begin
          state_q <= s_next;
          rc_q    <= rc_q + RStep;
          if (rc_q + RStep == 4'd12) begin
            fin_sout  <= s_next;
            tag_valid <= 1'b1;
            busy      <= 1'b0;
            st_q      <= StDone;
`ifdef ASCON_TAG_VERIFY_EN
            // A failed compare never releases the computed tag.
            tag_match <= (tag_in_q == tag_calc);
            tag_out   <= (tag_in_q == tag_calc) ? tag_calc : '0;
`else
            tag_out   <= tag_calc;
`endif
          end
        end
        default: begin
          st_q <= StIdle;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
